// File: rtl/mili_pkg.sv
// Shared sizing helpers and reset defaults for the serial sequence detector.
package mili_pkg;

    localparam int              DEF_PAT_W    = 4;
    localparam logic [3:0]      DEF_PAT_INIT = 4'b1011;
    localparam int              DEF_CNT_W    = 8;

    // Width of the matched-prefix state; never below one bit.
    function automatic int state_w(input int pat_w);
        return (pat_w < 3) ? 1 : $clog2(pat_w);
    endfunction

endpackage

// File: rtl/mili_fail_calc.sv
// Next-state computation for the detector: partial hit, full match (overlap
// border or restart) and mismatch fallback to the longest re-usable prefix.
module mili_fail_calc
    import mili_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int SW    = state_w(PAT_W)
) (
    input  logic [PAT_W-1:0] pat,
    input  logic [SW-1:0]    k,
    input  logic             a,
    input  logic             overlap,
    output logic [SW-1:0]    next_state
);

    int               kk;
    logic             exp_bit;
    logic             hit;
    logic             at_last;
    logic [PAT_W-1:0] seq;

    // True when the last len bits of s[0..last] equal the first len pattern bits.
    function automatic logic tail_matches(input logic [PAT_W-1:0] s,
                                          input logic [PAT_W-1:0] p,
                                          input int last, input int len);
        logic ok;
        ok = 1'b1;
        for (int m = 0; m < PAT_W; m++)
            for (int j = 0; j < PAT_W; j++)
                if (m < len && j == last + 1 - len + m && s[j] != p[PAT_W-1-m])
                    ok = 1'b0;
        return ok;
    endfunction

    always_comb kk = int'(k);

    always_comb begin
        exp_bit = 1'b0;
        for (int j = 0; j < PAT_W; j++)
            if (j == kk) exp_bit = pat[PAT_W-1-j];
    end

    assign hit     = (a == exp_bit);
    assign at_last = (k == SW'(PAT_W - 1));

    // seq[0..kk] is the received string: the matched prefix followed by a.
    always_comb begin
        seq = '0;
        for (int j = 0; j < PAT_W; j++) begin
            if (j < kk)
                seq[j] = pat[PAT_W-1-j];
            else if (j == kk)
                seq[j] = a;
        end
    end

    always_comb begin
        next_state = '0;
        if (hit && !at_last)
            next_state = k + SW'(1);
        else if (hit && !overlap)
            next_state = '0;
        else
            for (int len = 1; len < PAT_W; len++)
                if (len <= kk && tail_matches(seq, pat, kk, len))
                    next_state = SW'(len);
    end

endmodule

// File: rtl/mili_seq_detector.sv
// Mealy serial sequence detector with runtime-loadable pattern, selectable
// overlap mode and a saturating match counter.
module mili_seq_detector
    import mili_pkg::*;
#(
    parameter int               PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DEF_PAT_INIT),
    parameter int               CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      a,
    input  logic                      load,
    input  logic [PAT_W-1:0]          pat_in,
    input  logic                      overlap,
    input  logic                      clr_cnt,
    output logic                      y,
    output logic [state_w(PAT_W)-1:0] state_o,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      cnt_sat
);

    localparam int              SW   = state_w(PAT_W);
    localparam logic [SW-1:0]   LAST = SW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_r;
    logic [SW-1:0]    state_r;
    logic [SW-1:0]    state_nxt;
    logic [CNT_W-1:0] cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    mili_fail_calc #(
        .PAT_W (PAT_W),
        .SW    (SW)
    ) u_fail_calc (
        .pat        (pat_r),
        .k          (state_r),
        .a          (a),
        .overlap    (overlap),
        .next_state (state_nxt)
    );

    // Match is flagged on the final bit itself, gated off by reset and reload.
    assign y = en & ~rst & ~load & (state_r == LAST) & (a == pat_r[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r   <= PAT_INIT;
            state_r <= '0;
        end else if (load) begin
            pat_r   <= pat_in;
            state_r <= '0;
        end else if (en) begin
            state_r <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_r <= '0;
        else if (clr_cnt)
            cnt_r <= '0;
        else if (y)
            cnt_r <= sat_inc(cnt_r);
    end

    assign state_o   = state_r;
    assign match_cnt = cnt_r;
    assign cnt_sat   = &cnt_r;

endmodule
